// File: rtl/rc_pkg.sv
// Shared definitions for the rollercoaster (3n+1 / n/2) sequencer and step datapath.
package rc_pkg;

    localparam int RC_WIDTH = 25;

    typedef enum logic [1:0] {
        RC_OK      = 2'd0,
        RC_OVF     = 2'd1,
        RC_TIMEOUT = 2'd2,
        RC_ZERO    = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rc_step.sv
// One rollercoaster step: halve an even value, 3n+1 an odd one, flag unsigned overflow.
module rc_step
    import rc_pkg::*;
#(
    parameter int WIDTH = RC_WIDTH
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] next,
    output logic             ovf
);

    logic [WIDTH+1:0] tmp;

    // 3n+1 as n + (2n+1), two bits wider so the carry-out is visible
    assign tmp = {2'b00, cur} + {1'b0, cur, 1'b1};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next = cur >> 1;
        ovf  = 1'b0;
        if (cur[0]) begin
            next = tmp[WIDTH-1:0];
            ovf  = |tmp[WIDTH+1:WIDTH];
        end
    end

endmodule

// File: rtl/rollercoaster_sequencer.sv
// Job controller: accepts a start number, iterates rc_step once per clock,
// and returns steps, peak and a status code over valid/ready handshakes.
module rollercoaster_sequencer
    import rc_pkg::*;
#(
    parameter int WIDTH     = RC_WIDTH,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 65535
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_num,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_steps,
    output logic [WIDTH-1:0] res_peak,
    output logic [1:0]       res_status,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    state_t           state_q, state_d;
    status_t          status_q, status_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] peak_q, peak_d;
    logic [CNT_W-1:0] steps_q, steps_d;

    logic [WIDTH-1:0] step_next;
    logic             step_ovf;

    rc_step #(.WIDTH(WIDTH)) u_step (
        .cur  (cur_q),
        .next (step_next),
        .ovf  (step_ovf)
    );

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q  <= ST_IDLE;
            status_q <= RC_OK;
            cur_q    <= '0;
            peak_q   <= '0;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cur_q    <= cur_d;
            peak_q   <= peak_d;
            steps_q  <= steps_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cur_d    = cur_q;
        peak_d   = peak_q;
        steps_d  = steps_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    cur_d   = start_num;
                    peak_d  = start_num;
                    steps_d = '0;
                    if (start_num == '0) begin
                        status_d = RC_ZERO;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (cur_q == WIDTH'(1)) begin
                    status_d = RC_OK;
                    state_d  = ST_DONE;
                end else if (steps_q == MAX_CNT) begin
                    status_d = RC_TIMEOUT;
                    state_d  = ST_DONE;
                end else if (step_ovf) begin
                    // the failing step is counted but its value is discarded
                    status_d = RC_OVF;
                    steps_d  = steps_q + CNT_W'(1);
                    state_d  = ST_DONE;
                end else begin
                    cur_d   = step_next;
                    steps_d = steps_q + CNT_W'(1);
                    if (step_next > peak_q) peak_d = step_next;
                end
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state_q == ST_IDLE);
        busy        = (state_q == ST_RUN);
        res_valid   = (state_q == ST_DONE);
        res_steps   = steps_q;
        res_peak    = peak_q;
        res_status  = status_q;
    end

endmodule

// File: tb/tb_rollercoaster_sequencer.sv
// Directed bench for rollercoaster_sequencer: default build plus a MAX_STEPS=4 build.
module tb_rollercoaster_sequencer;

    localparam int W = 25;
    localparam int C = 16;

    logic clk = 1'b0;
    logic reset;

    logic          start_valid, start_ready, res_valid, res_ready, busy;
    logic [W-1:0]  start_num, res_peak;
    logic [C-1:0]  res_steps;
    logic [1:0]    res_status;

    logic          t_start_valid, t_start_ready, t_res_valid, t_res_ready, t_busy;
    logic [W-1:0]  t_start_num, t_res_peak;
    logic [C-1:0]  t_res_steps;
    logic [1:0]    t_res_status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rollercoaster_sequencer #(.WIDTH(W), .CNT_W(C), .MAX_STEPS(65535)) dut (
        .clock(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready), .start_num(start_num),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_steps(res_steps), .res_peak(res_peak), .res_status(res_status),
        .busy(busy)
    );

    rollercoaster_sequencer #(.WIDTH(W), .CNT_W(C), .MAX_STEPS(4)) dut_t (
        .clock(clk), .reset(reset),
        .start_valid(t_start_valid), .start_ready(t_start_ready), .start_num(t_start_num),
        .res_valid(t_res_valid), .res_ready(t_res_ready),
        .res_steps(t_res_steps), .res_peak(t_res_peak), .res_status(t_res_status),
        .busy(t_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one job on the default instance; lat = edges from accept to res_valid.
    task automatic run_job(input logic [W-1:0] n, output int lat);
        @(negedge clk);
        check("start_ready_before_accept", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        start_num   = n;
        @(negedge clk);
        start_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_after_consume_ready", 32'(start_ready), 32'd1);
        check("idle_after_consume_valid", 32'(res_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [C-1:0] hold_steps;
        logic [W-1:0] hold_peak;
        logic [1:0]   hold_status;

        reset = 1'b1;
        start_valid = 1'b0; start_num = '0; res_ready = 1'b0;
        t_start_valid = 1'b0; t_start_num = '0; t_res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_steps", 32'(res_steps), 32'd0);
        check("rst_peak", 32'(res_peak), 32'd0);
        check("rst_status", 32'(res_status), 32'd0);
        reset = 1'b0;

        // start 1: immediately done, one edge after accept
        run_job(25'd1, lat);
        check("n1_latency", 32'(lat), 32'd1);
        check("n1_steps", 32'(res_steps), 32'd0);
        check("n1_peak", 32'(res_peak), 32'd1);
        check("n1_status", 32'(res_status), 32'd0);
        consume();

        // 6,3,10,5,16,8,4,2,1
        run_job(25'd6, lat);
        check("n6_latency", 32'(lat), 32'd9);
        check("n6_steps", 32'(res_steps), 32'd8);
        check("n6_peak", 32'(res_peak), 32'd16);
        check("n6_status", 32'(res_status), 32'd0);
        consume();

        run_job(25'd27, lat);
        check("n27_latency", 32'(lat), 32'd112);
        check("n27_steps", 32'(res_steps), 32'd111);
        check("n27_peak", 32'(res_peak), 32'd9232);
        check("n27_status", 32'(res_status), 32'd0);
        consume();

        // largest value: first 3n+1 carries out of the register
        run_job(25'h1FFFFFF, lat);
        check("ovf_steps", 32'(res_steps), 32'd1);
        check("ovf_peak", 32'(res_peak), 32'h1FFFFFF);
        check("ovf_status", 32'(res_status), 32'd1);
        consume();

        run_job(25'd0, lat);
        check("zero_latency", 32'(lat), 32'd0);
        check("zero_steps", 32'(res_steps), 32'd0);
        check("zero_peak", 32'(res_peak), 32'd0);
        check("zero_status", 32'(res_status), 32'd3);
        consume();

        // budget of 4 steps: 27,82,41,124,62
        @(negedge clk);
        check("t_start_ready", 32'(t_start_ready), 32'd1);
        t_start_valid = 1'b1;
        t_start_num   = 25'd27;
        @(negedge clk);
        t_start_valid = 1'b0;
        lat = 0;
        while (!t_res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("to_latency", 32'(lat), 32'd5);
        check("to_steps", 32'(t_res_steps), 32'd4);
        check("to_peak", 32'(t_res_peak), 32'd124);
        check("to_status", 32'(t_res_status), 32'd2);
        hold_steps  = t_res_steps;
        hold_peak   = t_res_peak;
        hold_status = t_res_status;
        // back-pressure with a competing start request that must be ignored
        t_start_valid = 1'b1;
        t_start_num   = 25'd6;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(t_res_valid), 32'd1);
            check("hold_start_ready", 32'(t_start_ready), 32'd0);
            check("hold_steps", 32'(t_res_steps), 32'(hold_steps));
            check("hold_peak", 32'(t_res_peak), 32'(hold_peak));
            check("hold_status", 32'(t_res_status), 32'(hold_status));
        end
        t_start_valid = 1'b0;
        t_res_ready   = 1'b1;
        @(negedge clk);
        t_res_ready = 1'b0;
        check("to_back_idle", 32'(t_start_ready), 32'd1);
        check("to_valid_low", 32'(t_res_valid), 32'd0);

        // reset in the middle of a long job
        @(negedge clk);
        start_valid = 1'b1;
        start_num   = 25'd27;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_start_ready", 32'(start_ready), 32'd1);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_steps", 32'(res_steps), 32'd0);

        run_job(25'd6, lat);
        check("post_rst_latency", 32'(lat), 32'd9);
        check("post_rst_steps", 32'(res_steps), 32'd8);
        check("post_rst_status", 32'(res_status), 32'd0);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
